// File: rtl/rr_mux_arbiter_8.sv
// Round-robin arbiter for an 8-to-1 single-bit mux path.
// Grants one requester at a time for a burst of up to BURST_LEN beats under valid/ready.
module rr_mux_arbiter_8 #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] data_in,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       out_valid,
    output logic       out_data,
    input  logic       out_ready,
    output logic [7:0] beat_ack
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t           state, state_n;
    logic [7:0]       grant_n;
    logic [2:0]       sel_n;
    logic [2:0]       ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       winner;
    logic [2:0]       idx;
    logic             found;
    logic             busy;
    logic             xfer;

    assign busy      = (state == BUSY);
    assign out_valid = busy & req[sel];
    assign out_data  = busy & data_in[sel];
    assign xfer      = out_valid & out_ready;
    assign beat_ack  = grant & {8{xfer}};

    // Priority scan starting at ptr, wrapping modulo 8.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + i[2:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    sel_n   = winner;
                    grant_n = 8'd1 << winner;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                // A dropped request releases immediately, even mid-burst.
                if ((xfer && (cnt == LAST_BEAT)) || !req[sel]) begin
                    state_n = IDLE;
                    grant_n = 8'd0;
                    ptr_n   = sel + 3'd1;
                    cnt_n   = '0;
                end else if (xfer) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= 8'd0;
            sel   <= 3'd0;
            ptr   <= 3'd0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Directed bench for rr_mux_arbiter_8: one BURST_LEN=4 instance and one BURST_LEN=1 instance.
module tb_rr_mux_arbiter_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req, data_in, grant, beat_ack;
    logic [2:0] sel;
    logic       out_valid, out_data, out_ready;

    logic [7:0] req1, data1, grant1, ack1;
    logic [2:0] sel1;
    logic       valid1, odata1, ready1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter_8 #(.BURST_LEN(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .grant(grant), .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .beat_ack(beat_ack)
    );

    rr_mux_arbiter_8 #(.BURST_LEN(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .data_in(data1),
        .grant(grant1), .sel(sel1), .out_valid(valid1), .out_data(odata1),
        .out_ready(ready1), .beat_ack(ack1)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; data_in = 8'h00; out_ready = 1'b0;
        req1 = 8'h00; data1 = 8'h00; ready1 = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        mid();
        total++;
        if (grant !== 8'h00 || sel !== 3'd0 || out_valid !== 1'b0 || out_data !== 1'b0 || beat_ack !== 8'h00) begin
            $display("FAIL reset: grant=%h sel=%0d valid=%b data=%b ack=%h, required 00/0/0/0/00",
                     grant, sel, out_valid, out_data, beat_ack);
        end else passed++;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h04; data_in = 8'h04; out_ready = 1'b1;
        mid();
        total++;
        if (grant !== 8'h00 || out_valid !== 1'b0) begin
            $display("FAIL single_idle: grant=%h valid=%b, required 00/0", grant, out_valid);
        end else passed++;
        step();
        for (int k = 0; k < 4; k++) begin
            mid();
            total++;
            if (grant !== 8'h04 || sel !== 3'd2 || beat_ack !== 8'h04 || out_data !== 1'b1) begin
                $display("FAIL single_beat%0d: grant=%h sel=%0d ack=%h data=%b, required 04/2/04/1",
                         k, grant, sel, beat_ack, out_data);
            end else passed++;
            step();
        end
        mid();
        total++;
        if (grant !== 8'h00 || beat_ack !== 8'h00) begin
            $display("FAIL single_gap: grant=%h ack=%h, required 00/00", grant, beat_ack);
        end else passed++;
        step();
        mid();
        total++;
        if (grant !== 8'h04 || sel !== 3'd2) begin
            $display("FAIL single_regrant: grant=%h sel=%0d, required 04/2", grant, sel);
        end else passed++;
        step();
    endtask

    task automatic test_all_req();
        logic [7:0] exp;
        do_reset();
        req = 8'hFF; data_in = 8'hA5; out_ready = 1'b1;
        for (int g = 0; g < 9; g++) begin
            exp = 8'd1 << (g % 8);
            mid();
            total++;
            if (grant !== 8'h00) begin
                $display("FAIL allreq_idle%0d: grant=%h, required 00", g, grant);
            end else passed++;
            step();
            for (int k = 0; k < 4; k++) begin
                mid();
                total++;
                if (grant !== exp || beat_ack !== exp || sel !== 3'(g % 8)) begin
                    $display("FAIL allreq_g%0d_b%0d: grant=%h ack=%h sel=%0d, required %h/%h/%0d",
                             g, k, grant, beat_ack, sel, exp, exp, g % 8);
                end else passed++;
                step();
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 8'h21; data_in = 8'h00; out_ready = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            mid();
            total++;
            if (grant !== 8'h01 || beat_ack !== 8'h01) begin
                $display("FAIL drop_beat%0d: grant=%h ack=%h, required 01/01", k, grant, beat_ack);
            end else passed++;
            step();
        end
        req = 8'h20;
        mid();
        total++;
        if (out_valid !== 1'b0 || beat_ack !== 8'h00 || grant !== 8'h01) begin
            $display("FAIL drop_cycle: valid=%b ack=%h grant=%h, required 0/00/01", out_valid, beat_ack, grant);
        end else passed++;
        step();
        mid();
        total++;
        if (grant !== 8'h00) begin
            $display("FAIL drop_release: grant=%h, required 00", grant);
        end else passed++;
        step();
        for (int k = 0; k < 4; k++) begin
            mid();
            total++;
            if (grant !== 8'h20 || sel !== 3'd5 || beat_ack !== 8'h20) begin
                $display("FAIL drop_next_b%0d: grant=%h sel=%0d ack=%h, required 20/5/20", k, grant, sel, beat_ack);
            end else passed++;
            step();
        end
        mid();
        total++;
        if (grant !== 8'h00) begin
            $display("FAIL drop_next_end: grant=%h, required 00", grant);
        end else passed++;
        step();
    endtask

    task automatic test_backpressure();
        logic [6:0] pat;
        logic       d;
        int         acks;
        pat  = 7'b1011001;
        acks = 0;
        do_reset();
        req = 8'h08; data_in = 8'h00; out_ready = 1'b1;
        step();
        for (int k = 0; k < 7; k++) begin
            out_ready = pat[k];
            d = (k % 3 == 1);
            data_in = {4'h0, d, 3'b000};
            mid();
            if (beat_ack[3]) acks++;
            total++;
            if (grant !== 8'h08 || out_data !== d || beat_ack !== (pat[k] ? 8'h08 : 8'h00)) begin
                $display("FAIL bp_cycle%0d: grant=%h data=%b ack=%h, required 08/%b/%h",
                         k, grant, out_data, beat_ack, d, pat[k] ? 8'h08 : 8'h00);
            end else passed++;
            step();
        end
        mid();
        total++;
        if (acks !== 4 || grant !== 8'h00) begin
            $display("FAIL bp_total: acks=%0d grant=%h, required 4/00", acks, grant);
        end else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h40; data_in = 8'h00; out_ready = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            mid();
            total++;
            if (grant !== 8'h40 || beat_ack !== 8'h40) begin
                $display("FAIL rstmid_beat%0d: grant=%h ack=%h, required 40/40", k, grant, beat_ack);
            end else passed++;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 8'h41;
        mid();
        total++;
        if (grant !== 8'h00 || sel !== 3'd0 || out_valid !== 1'b0 || beat_ack !== 8'h00) begin
            $display("FAIL rstmid_after: grant=%h sel=%0d valid=%b ack=%h, required 00/0/0/00",
                     grant, sel, out_valid, beat_ack);
        end else passed++;
        step();
        mid();
        total++;
        if (grant !== 8'h01 || sel !== 3'd0) begin
            $display("FAIL rstmid_regrant: grant=%h sel=%0d, required 01/0", grant, sel);
        end else passed++;
        step();
    endtask

    task automatic test_burst1();
        logic [7:0] exp;
        do_reset();
        req1 = 8'h81; data1 = 8'h80; ready1 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp = (g % 2 == 0) ? 8'h01 : 8'h80;
            mid();
            total++;
            if (grant1 !== 8'h00) begin
                $display("FAIL b1_idle%0d: grant=%h, required 00", g, grant1);
            end else passed++;
            step();
            mid();
            total++;
            if (grant1 !== exp || ack1 !== exp || odata1 !== exp[7]) begin
                $display("FAIL b1_grant%0d: grant=%h ack=%h data=%b, required %h/%h/%b",
                         g, grant1, ack1, odata1, exp, exp, exp[7]);
            end else passed++;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_drop();
        test_backpressure();
        test_reset_mid();
        test_burst1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
